// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared types and helpers for the bit-serial adder
package serial_adder_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Bit-position counter width; never below one bit so the counter always exists.
  function automatic int count_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/serial_adder_adder_1.sv
// rtl/serial_adder_adder_1.sv - adder_1 single-bit full-adder cell
module adder_1 (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic c_out
);

  assign sum   = a ^ b ^ c_in;
  assign c_out = (a & b) | (a & c_in) | (b & c_in);

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial N-bit adder around one adder_1 cell, LSB first
// Optional subtract mode under `SERIAL_ADDER_SUB_EN (adds the sub port).
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         c_in,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic         sub,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         c_out,
  output logic         overflow
);

  localparam int CW = count_width(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t        state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  sum_sh;
  logic          carry;
  logic [CW-1:0] count;
  logic          fa_sum;
  logic          fa_cout;
  logic [N-1:0]  b_load;
  logic          carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  // Subtract is a + ~b + 1; the caller's carry-in is overridden.
  assign b_load     = sub ? ~b : b;
  assign carry_load = sub ? 1'b1 : c_in;
`else
  assign b_load     = b;
  assign carry_load = c_in;
`endif

  adder_1 u_adder_1 (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .c_in  (carry),
    .sum   (fa_sum),
    .c_out (fa_cout)
  );

  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign sum       = sum_sh;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      a_sh     <= '0;
      b_sh     <= '0;
      sum_sh   <= '0;
      carry    <= 1'b0;
      count    <= '0;
      c_out    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_sh  <= a;
            b_sh  <= b_load;
            carry <= carry_load;
            count <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          sum_sh <= {fa_sum, sum_sh[N-1:1]};
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_cout;
          if (count == LAST) begin
            // Carry into the MSB is the registered carry; carry out is the cell's.
            overflow <= carry ^ fa_cout;
            c_out    <= fa_cout;
            state    <= S_DONE;
          end else begin
            count <= count + 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at N=8
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       c_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
  logic       sub = 1'b0;
`endif
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       c_out;
  logic       overflow;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int accept_cyc = 0;
  logic prev_ov = 1'b0;
  logic [9:0] sb[$];

  serial_adder #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .c_in      (c_in),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .c_out     (c_out),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever a result is handed off.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (out_valid && !prev_ov && !rst) chk("latency", cyc - accept_cyc, 8);
      prev_ov = out_valid;
      if (out_valid && out_ready && !rst) begin
        if (sb.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          logic [9:0] e;
          e = sb.pop_front();
          chk("sum", int'(sum), int'(e[9:2]));
          chk("c_out", int'(c_out), int'(e[1]));
          chk("overflow", int'(overflow), int'(e[0]));
        end
      end
    end
  end

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic ts, input logic [7:0] es, input logic ec, input logic eo);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 0, 1);
      return;
    end
    a = ta;
    b = tb;
    c_in = tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`else
    if (ts) c_in = tc;
`endif
    in_valid = 1'b1;
    accept_cyc = cyc + 1;
    sb.push_back({es, ec, eo});
    @(negedge clk);
    in_valid = 1'b0;
    chk("in_ready_after_accept", int'(in_ready), 0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #23;
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_sum", int'(sum), 0);
    @(negedge clk);
    rst = 1'b0;

    send(8'h03, 8'h05, 1'b0, 1'b0, 8'h08, 1'b0, 1'b0);
    drain();
    send(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
    drain();
    send(8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    drain();
    send(8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1);
    drain();
    send(8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
    drain();

    // Output back-pressure
    out_ready = 1'b0;
    send(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, 1'b0);
    begin
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("bp_out_valid_seen", int'(out_valid), 1);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid_hold", int'(out_valid), 1);
      chk("bp_sum_hold", int'(sum), 8'h47);
      chk("bp_in_ready", int'(in_ready), 0);
      a = 8'hAA;
      b = 8'h55;
      in_valid = (i % 2 == 0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();
    chk("bp_back_to_idle", int'(in_ready), 1);
    send(8'hC8, 8'h64, 1'b0, 1'b0, 8'h2C, 1'b1, 1'b0);
    drain();

    // Reset mid-operation
    send(8'h55, 8'h0F, 1'b0, 1'b0, 8'h64, 1'b0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    void'(sb.pop_back());
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_sum", int'(sum), 0);
    chk("mid_rst_c_out", int'(c_out), 0);
    chk("mid_rst_overflow", int'(overflow), 0);
    @(negedge clk);
    rst = 1'b0;
    send(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, 1'b0);
    drain();

`ifdef SERIAL_ADDER_SUB_EN
    send(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0);
    drain();
    send(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    drain();
`endif

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
